// File: rtl/game_frame_scheduler_pkg.sv
// game_frame_scheduler_pkg: shared widths, game-state and scheduler encodings, screen defaults, renderer colours
package game_frame_scheduler_pkg;
  typedef logic [7:0] ubyte;
  typedef enum logic [1:0] {
    GAME_MENU    = 2'd0,
    GAME_RUNNING = 2'd1,
    GAME_PAUSE   = 2'd2,
    GAME_OVER    = 2'd3
  } game_state_e;
  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_SCAN  = 2'd1,
    SCH_FLUSH = 2'd2,
    SCH_TICK  = 2'd3
  } sched_e;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_CYAN  = 3'b011;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;
endpackage

// File: rtl/game_frame_scheduler_game_state_fsm.sv
// game_state_fsm: sticky event flags and the game-state transition table, applied once per frame on tick
module game_state_fsm
  import game_frame_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_key,
  input  logic        pause_key,
  input  logic        collision,
  output game_state_e game_state
);
  logic start_q, start_d, pause_q, pause_d, coll_q, coll_d;
  game_state_e state_q, state_d;
  // flags collect events all frame; tick consumes them and drops anything arriving in the same cycle
  always_comb begin
    start_d = tick ? 1'b0 : start_q | start_key;
    pause_d = tick ? 1'b0 : pause_q | pause_key;
    coll_d  = tick ? 1'b0 : coll_q | collision;
    state_d = state_q;
    if (tick)
      case (state_q)
        GAME_MENU:    state_d = start_q ? GAME_RUNNING : GAME_MENU;
        GAME_RUNNING: state_d = coll_q ? GAME_OVER : pause_q ? GAME_PAUSE : GAME_RUNNING;
        GAME_PAUSE:   state_d = pause_q ? GAME_RUNNING : GAME_PAUSE;
        default:      state_d = start_q ? GAME_MENU : GAME_OVER;
      endcase
  end
  // game-state and flag registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
      coll_q  <= 1'b0;
      state_q <= GAME_MENU;
    end else begin
      start_q <= start_d;
      pause_q <= pause_d;
      coll_q  <= coll_d;
      state_q <= state_d;
    end
  assign game_state = state_q;
endmodule

// File: rtl/game_frame_scheduler.sv
// game_frame_scheduler: per-frame pixel scan, plot pipeline and frame tick; DINO_FRAME_RATE_LIMIT_EN gates frame starts on a fixed period
module game_frame_scheduler
  import game_frame_scheduler_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int FRAME_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startKey,
  input  logic       pauseKey,
  input  logic       collision,
  input  logic [2:0] colMenu,
  input  logic [2:0] colRun,
  input  logic [2:0] colPause,
  input  logic [2:0] colOver,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       frameClk,
  output logic [1:0] gameState,
  output logic [7:0] vgaX,
  output logic [7:0] vgaY,
  output logic [2:0] vgaColor,
  output logic       vgaPlot
);
  sched_e st_q, st_d;
  ubyte x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic plot_q, plot_d, go, last_x, last_y;
  game_state_e gs;
`ifdef DINO_FRAME_RATE_LIMIT_EN
  localparam int PW = $clog2(FRAME_PERIOD + 1);
  logic [PW-1:0] per_q, per_d;
  assign go = per_q == PW'(FRAME_PERIOD - 1);
  // free-running period counter; its wrap cycle is the only moment a frame may start
  always_comb per_d = go ? '0 : per_q + 1'b1;
  // period counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) per_q <= '0;
    else per_q <= per_d;
`else
  assign go = FRAME_PERIOD >= 0;
`endif
  assign last_x = x_q == ubyte'(SCREEN_W - 1);
  assign last_y = y_q == ubyte'(SCREEN_H - 1);
  // scan sequencing: idle, raster scan with x fastest, flush of the last pixel, then the tick
  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    vx_d   = x_q;
    vy_d   = y_q;
    plot_d = st_q == SCH_SCAN;
    case (st_q)
      SCH_IDLE:  st_d = go ? SCH_SCAN : SCH_IDLE;
      SCH_SCAN: begin
        x_d  = last_x ? 8'd0 : x_q + 8'd1;
        y_d  = !last_x ? y_q : last_y ? 8'd0 : y_q + 8'd1;
        st_d = last_x && last_y ? SCH_FLUSH : SCH_SCAN;
      end
      SCH_FLUSH: st_d = SCH_TICK;
      default:   st_d = SCH_IDLE;
    endcase
  end
  // scan state, counters and the one-cycle coordinate-to-plot delay
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q   <= SCH_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
      plot_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      plot_q <= plot_d;
    end
  game_state_fsm u_game_state_fsm (
    .clk       (clk),
    .rst       (reset),
    .tick      (frameClk),
    .start_key (startKey),
    .pause_key (pauseKey),
    .collision (collision),
    .game_state(gs)
  );
  assign x         = x_q;
  assign y         = y_q;
  assign vgaX      = vx_q;
  assign vgaY      = vy_q;
  assign vgaPlot   = plot_q;
  assign frameClk  = st_q == SCH_TICK;
  assign gameState = gs;
  assign vgaColor  = !plot_q ? 3'd0 :
                     gs == GAME_MENU ? colMenu :
                     gs == GAME_RUNNING ? colRun :
                     gs == GAME_PAUSE ? colPause : colOver;
endmodule

// File: tb/tb_game_frame_scheduler.sv
// tb_game_frame_scheduler: random and directed stimulus checked every cycle against a frame-position model
module tb_game_frame_scheduler;
  localparam int W  = 20;
  localparam int H  = 12;
  localparam int FP = 300;
  localparam int L  = W * H + 3;
  logic clk = 1'b0;
  logic reset, startKey, pauseKey, collision;
  logic [2:0] colMenu, colRun, colPause, colOver;
  logic [7:0] x, y, vgaX, vgaY;
  logic [2:0] vgaColor;
  logic [1:0] gameState;
  logic frameClk, vgaPlot;
  int checks = 0, failures = 0;
  int p, gs, cyc, first_fc, last_fc, nplot, fx, fy, lx, ly;
  bit fs, fpz, fc, seen_fc, got_first;
  always #5 clk = ~clk;
  game_frame_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .FRAME_PERIOD(FP)) dut (
    .clk(clk), .reset(reset), .startKey(startKey), .pauseKey(pauseKey), .collision(collision),
    .colMenu(colMenu), .colRun(colRun), .colPause(colPause), .colOver(colOver),
    .x(x), .y(y), .frameClk(frameClk), .gameState(gameState),
    .vgaX(vgaX), .vgaY(vgaY), .vgaColor(vgaColor), .vgaPlot(vgaPlot)
  );
  function automatic int next_state(int s, bit st, bit pz, bit cl);
    if (s == 0) return st ? 1 : 0;
    if (s == 1) return cl ? 3 : pz ? 2 : 1;
    if (s == 2) return pz ? 1 : 2;
    return st ? 0 : 3;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic compare();
    bit scan, plot;
    logic [2:0] ec;
    scan = p >= 1 && p <= W * H;
    plot = p >= 2 && p <= W * H + 1;
    ec = !plot ? 3'd0 : gs == 0 ? colMenu : gs == 1 ? colRun : gs == 2 ? colPause : colOver;
    chk("x", x, scan ? (p - 1) % W : 0);
    chk("y", y, scan ? (p - 1) / W : 0);
    chk("vgaPlot", vgaPlot, plot);
    chk("vgaX", vgaX, plot ? (p - 2) % W : 0);
    chk("vgaY", vgaY, plot ? (p - 2) / W : 0);
    chk("vgaColor", vgaColor, ec);
    chk("frameClk", frameClk, p == L - 1);
    chk("gameState", gameState, gs);
    if (vgaPlot && !seen_fc) begin
      nplot++;
      if (!got_first) begin fx = vgaX; fy = vgaY; got_first = 1; end
      lx = vgaX; ly = vgaY;
    end
    if (frameClk === 1'b1) begin
      if (!seen_fc) first_fc = cyc;
`ifdef DINO_FRAME_RATE_LIMIT_EN
      else chk("frame_spacing", cyc - last_fc, 300);
`else
      else chk("frame_spacing", cyc - last_fc, 243);
`endif
      last_fc = cyc;
      seen_fc = 1;
    end
  endtask
  task automatic model_advance();
    bit go;
`ifdef DINO_FRAME_RATE_LIMIT_EN
    go = (cyc % FP) == FP - 1;
`else
    go = 1;
`endif
    if (p == L - 1) begin
      gs = next_state(gs, fs, fpz, fc);
      fs = 0; fpz = 0; fc = 0; p = 0;
    end else begin
      fs |= startKey; fpz |= pauseKey; fc |= collision;
      p = p == 0 ? (go ? 1 : 0) : p + 1;
    end
    cyc++;
  endtask
  task automatic step(input bit s, input bit pz, input bit cl);
    startKey = s; pauseKey = pz; collision = cl;
    colMenu = 3'($urandom); colRun = 3'($urandom); colPause = 3'($urandom); colOver = 3'($urandom);
    @(posedge clk);
    model_advance();
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    @(negedge clk);
    startKey = 0; pauseKey = 0; collision = 0;
    reset = 1;
    #1;
    p = 0; gs = 0; fs = 0; fpz = 0; fc = 0; cyc = 0;
    seen_fc = 0; got_first = 0; nplot = 0;
    compare();
    @(negedge clk);
    compare();
    reset = 0;
    #1 compare();
  endtask
  task automatic to_tick();
    for (int i = 0; i < 2000 && p != L - 1; i++) step(0, 0, 0);
    if (p != L - 1) begin
      checks++; failures++;
      $display("FAIL tick_timeout: got position %0d expected %0d", p, L - 1);
    end
  endtask
  initial begin
    reset = 1; startKey = 0; pauseKey = 0; collision = 0;
    colMenu = 0; colRun = 0; colPause = 0; colOver = 0;
    p = 0; gs = 0; cyc = 0;
    do_reset();
    to_tick();
    step(1, 0, 0);
`ifdef DINO_FRAME_RATE_LIMIT_EN
    chk("first_tick_cycle", first_fc, 541);
`else
    chk("first_tick_cycle", first_fc, 242);
`endif
    chk("plot_count", nplot, 240);
    chk("first_plot_x", fx, 0);
    chk("first_plot_y", fy, 0);
    chk("last_plot_x", lx, 19);
    chk("last_plot_y", ly, 11);
    chk("menu_after_frame1", gameState, 0);
    to_tick();
    step(0, 0, 0);
    chk("start_in_tick_ignored", gameState, 0);
    repeat (50) step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    chk("menu_until_tick", gameState, 0);
    to_tick();
    step(0, 0, 0);
    chk("running_after_start", gameState, 1);
    repeat (30) step(0, 0, 0);
    step(0, 1, 0);
    repeat (30) step(0, 0, 0);
    step(0, 0, 1);
    to_tick();
    step(0, 0, 0);
    chk("collision_beats_pause", gameState, 3);
    step(1, 0, 0);
    to_tick();
    step(0, 0, 0);
    chk("over_to_menu", gameState, 0);
    for (int i = 0; i < 12 * L; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 199) == 0);
    do_reset();
    step(1, 0, 0);
    to_tick();
    step(0, 0, 0);
    chk("running_before_reset", gameState, 1);
    for (int i = 0; i < 2000 && p != 6 * W + 11; i++) step(0, 0, 0);
    chk("reset_point_x", x, 10);
    chk("reset_point_y", y, 6);
    do_reset();
    chk("reset_state_menu", gameState, 0);
    chk("reset_plot_low", vgaPlot, 0);
    to_tick();
    step(0, 0, 0);
`ifdef DINO_FRAME_RATE_LIMIT_EN
    chk("tick_after_reset", first_fc, 541);
`else
    chk("tick_after_reset", first_fc, 242);
`endif
    chk("restart_plot_x", fx, 0);
    chk("restart_plot_y", fy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_frame_scheduler.md
# game_frame_scheduler

Sequences one full-screen render pass per game frame and owns the game-state machine. Scans pixel coordinates into the four game-state renderers (menu, running, pause, over) and selects the active renderer's registered colour. Re-aligns that colour with its coordinates and drives the VGA adapter's plot interface. Emits the one-cycle `frameClk` tick that advances game logic and renderer animation.

## Interface
Parameters:
- `SCREEN_W`, default 160: pixels per row.
- `SCREEN_H`, default 120: rows per frame.
- `FRAME_PERIOD`, default 833333: clk cycles per frame slot (50 MHz / 60 Hz); used only with the rate limiter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `startKey`  in  1  single-cycle pulse, already synchronised to `clk`.
- `pauseKey`  in  1  single-cycle pulse, already synchronised to `clk`.
- `collision`  in  1  level from collision logic; sampled every cycle.
- `colMenu`, `colRun`, `colPause`, `colOver`  in  3 each  registered renderer colours; each is valid one cycle after `x`/`y`.
- `x`, `y`  out  8 each  scan coordinates to all renderers.
- `frameClk`  out  1  one-cycle end-of-frame tick.
- `gameState`  out  2  MENU=0, RUNNING=1, PAUSE=2, OVER=3.
- `vgaX`, `vgaY`  out  8 each  plot coordinates.
- `vgaColor`  out  3  plot colour.
- `vgaPlot`  out  1  write enable.

## Operation
Scheduler FSM has four states:
- IDLE: waits for the frame start; x=y=0.
- SCAN: presents one pixel per cycle, x fastest. x wraps at SCREEN_W-1 to 0 and increments y. The cycle presenting (SCREEN_W-1, SCREEN_H-1) moves to FLUSH.
- FLUSH: one cycle that plots the final pixel; x/y hold at 0.
- TICK: one cycle; `frameClk`=1; the pending game-state transition is applied; goes to IDLE.

Pixel pipeline:
- `vgaX`/`vgaY` are `x`/`y` delayed by one cycle.
- `vgaPlot` is "was in SCAN" delayed by one cycle.
- `vgaColor` is the renderer colour selected by `gameState`.
- `gameState` is constant for a whole frame, so the mux needs no delay.

Event latching: `startKey`, `pauseKey` and `collision` set sticky pending flags at any time. All flags clear in TICK.

Game-state transitions, evaluated only in TICK:
- MENU + start → RUNNING.
- RUNNING + collision → OVER. Collision has priority over pause.
- RUNNING + pause → PAUSE.
- PAUSE + pause → RUNNING.
- OVER + start → MENU.
- Any other combination leaves the state unchanged; its flags are discarded.

Arithmetic and boundaries:
- x/y counters are 8-bit and compare with `==` against W-1/H-1. Scanning never reaches 255.
- Events arriving during TICK itself are lost. They are neither applied nor kept.
- Reset mid-frame: the FSM returns to IDLE and `gameState` to MENU at once; no partial-frame tick is issued.

## Timing
Reset values: x=y=0, vgaX=vgaY=0, vgaColor=0, vgaPlot=0, frameClk=0, gameState=MENU, FSM=IDLE, pending flags=0, period counter=0.

Latency:
- Coordinate to plot is 1 cycle.
- First `vgaPlot` comes 1 cycle after SCAN entry.
- `vgaPlot` stays high for exactly W*H consecutive cycles per frame (19200 at default).
- TICK is the cycle after FLUSH. `gameState` changes on the edge that leaves TICK, so the next frame renders the new state.

Frame length without rate limiter: IDLE 1 + SCAN W*H + FLUSH 1 + TICK 1 = 19203 cycles at default.

## Configuration
`DINO_FRAME_RATE_LIMIT_EN`:
- Defined:
  - A free-running period counter wraps every FRAME_PERIOD cycles.
  - IDLE leaves to SCAN only on a wrap cycle, so frames start on a fixed cadence.
  - If the scan overruns a period, the next wrap is used; frames are never started mid-scan.
- Undefined:
  - No counter is built.
  - IDLE lasts exactly one cycle, giving back-to-back frames.
  - FRAME_PERIOD is ignored.

## Structure
Shared package/header holds:
- the `ubyte` width;
- the game-state encodings (GAME_MENU, GAME_RUNNING, GAME_PAUSE, GAME_OVER);
- the SCREEN_W/H defaults;
- the colour constants used by the renderers.

One sub-module: `game_state_fsm`. It takes the pending-flag latch, the transition table and the `gameState` register, and is enabled by the TICK strobe. The scan FSM, counters, period counter and pixel pipeline live in the top module.

## Test plan
- Reset, then idle one frame with no keys → 19200 plots, first at (0,0), last at (159,119). Colours equal `colMenu`. One `frameClk` at cycle 19202 after reset release (rate limiter off).
- `startKey` pulse mid-frame → `gameState` stays MENU until TICK, then becomes RUNNING. The next frame's plots carry `colRun`.
- RUNNING frame with `pauseKey` and `collision` in the same frame → state becomes OVER, not PAUSE. Then `startKey` → MENU after the following TICK.
- Reset asserted at pixel (80,60) → all outputs zero and state MENU within the same cycle. No `frameClk` is produced. After release, the scan restarts at (0,0).
- Rate limiter on, FRAME_PERIOD=20000 → successive `frameClk` pulses exactly 20000 cycles apart. With FRAME_PERIOD=10000, they are 20000 apart (overrun skips one wrap).
- `startKey` pulse exactly in the TICK cycle while in MENU → ignored; the state remains MENU after the next frame.
